// File: rtl/game_engine_nk_if.sv
// N x N, K-in-a-row two-player game engine: bus bundle for everything except clk/reset.
// Ports: isPlayer1Start/newGame/playerWrite/playerInput toward the engine;
//        gBoard/gameState/winner/moveCount/moveError back from it.
interface game_engine_nk_if #(
    parameter int N = 3
);
    localparam int IW = $clog2(N * N);
    localparam int CW = $clog2(N * N + 1);

    logic                 isPlayer1Start;
    logic                 newGame;
    logic                 playerWrite;
    logic [IW-1:0]        playerInput;
    logic [2*N*N-1:0]     gBoard;
    logic [2:0]           gameState;
    logic [1:0]           winner;
    logic [CW-1:0]        moveCount;
    logic                 moveError;

    // master drives moves and control, slave is the game engine
    modport master (
        output isPlayer1Start, newGame, playerWrite, playerInput,
        input  gBoard, gameState, winner, moveCount, moveError
    );

    modport slave (
        input  isPlayer1Start, newGame, playerWrite, playerInput,
        output gBoard, gameState, winner, moveCount, moveError
    );
endinterface

// File: rtl/game_engine_nk.sv
// N x N board, K-in-a-row two-player game engine with a turn/check/done FSM.
// Ports: clk, reset (sync, active-high), bus (slave): move strobe + cell index in;
//        packed board, state, winner, accepted-move count and a one-cycle error pulse out.
module game_engine_nk #(
    parameter int N = 3,
    parameter int K = 3
) (
    input  logic            clk,
    input  logic            reset,
    game_engine_nk_if.slave bus
);
    localparam int CELLS = N * N;
    localparam int IW    = $clog2(CELLS);
    localparam int CW    = $clog2(CELLS + 1);

    generate
        if (N < 3 || N > 6 || K < 3 || K > N) begin : g_bad_params
            $error("game_engine_nk: N must be 3..6 and K must be 3..N");
        end
    endgenerate

    typedef enum logic [2:0] {
        P1_TURN = 3'b001,
        P2_TURN = 3'b010,
        CHECK   = 3'b011,
        DONE    = 3'b100
    } state_t;

    state_t        state_q, state_d, start_state;
    logic [1:0]    board_q [CELLS];
    logic [1:0]    board_d [CELLS];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    winner_q, winner_d;
    logic          err_q, err_d;
    logic [1:0]    mover_q, mover_d;   // code of the player whose move CHECK evaluates
    logic          mover_won;
    logic          idx_ok;
    logic [1:0]    sel_cell;

    assign start_state = bus.isPlayer1Start ? P1_TURN : P2_TURN;

    // Addressed cell lookup; an index past the last cell matches nothing,
    // which is how out-of-range moves are detected.
    always_comb begin
        idx_ok   = 1'b0;
        sel_cell = 2'b00;
        for (int i = 0; i < CELLS; i++) begin
            if (bus.playerInput == IW'(i)) begin
                idx_ok   = 1'b1;
                sel_cell = board_q[i];
            end
        end
    end

    // Line search over the registered board for the last mover only.
    // Each cell is tried as the start of a run in four directions.
    always_comb begin
        logic run;
        mover_won = 1'b0;
        run       = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (c + K <= N) begin
                    run = 1'b1;
                    for (int t = 0; t < K; t++)
                        if (board_q[r*N + c + t] != mover_q) run = 1'b0;
                    if (run) mover_won = 1'b1;
                end
                if (r + K <= N) begin
                    run = 1'b1;
                    for (int t = 0; t < K; t++)
                        if (board_q[(r+t)*N + c] != mover_q) run = 1'b0;
                    if (run) mover_won = 1'b1;
                end
                if (r + K <= N && c + K <= N) begin
                    run = 1'b1;
                    for (int t = 0; t < K; t++)
                        if (board_q[(r+t)*N + c + t] != mover_q) run = 1'b0;
                    if (run) mover_won = 1'b1;
                end
                if (r + K <= N && c >= K - 1) begin
                    run = 1'b1;
                    for (int t = 0; t < K; t++)
                        if (board_q[(r+t)*N + c - t] != mover_q) run = 1'b0;
                    if (run) mover_won = 1'b1;
                end
            end
        end
    end

    // Next-state logic. newGame overrides everything, including a move
    // presented in the same cycle.
    always_comb begin
        logic [1:0] code;
        state_d  = state_q;
        board_d  = board_q;
        cnt_d    = cnt_q;
        winner_d = winner_q;
        err_d    = 1'b0;
        mover_d  = mover_q;
        code     = (state_q == P1_TURN) ? 2'b01 : 2'b10;

        if (bus.newGame) begin
            for (int i = 0; i < CELLS; i++) board_d[i] = 2'b00;
            cnt_d    = '0;
            winner_d = 2'b00;
            state_d  = start_state;
        end else begin
            case (state_q)
                P1_TURN, P2_TURN: begin
                    if (bus.playerWrite) begin
                        if (idx_ok && sel_cell == 2'b00) begin
                            for (int i = 0; i < CELLS; i++)
                                if (bus.playerInput == IW'(i)) board_d[i] = code;
                            cnt_d   = cnt_q + 1'b1;
                            mover_d = code;
                            state_d = CHECK;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    // A win on the board-filling move beats the draw.
                    if (mover_won) begin
                        state_d  = DONE;
                        winner_d = mover_q;
                    end else if (cnt_q == CW'(CELLS)) begin
                        state_d  = DONE;
                        winner_d = 2'b11;
                    end else begin
                        state_d = (mover_q == 2'b01) ? P2_TURN : P1_TURN;
                    end
                end
                DONE: begin
                end
                default: state_d = start_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= start_state;
            board_q  <= '{default: 2'b00};
            cnt_q    <= '0;
            winner_q <= 2'b00;
            err_q    <= 1'b0;
            mover_q  <= 2'b01;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            cnt_q    <= cnt_d;
            winner_q <= winner_d;
            err_q    <= err_d;
            mover_q  <= mover_d;
        end
    end

    always_comb begin
        bus.gBoard = '0;
        for (int i = 0; i < CELLS; i++) bus.gBoard[2*i +: 2] = board_q[i];
    end

    assign bus.gameState = state_q;
    assign bus.winner    = winner_q;
    assign bus.moveCount = cnt_q;
    assign bus.moveError = err_q;
endmodule

// File: tb/tb_game_engine_nk.sv
// Bench for game_engine_nk: directed scenarios plus random play on N=3 and N=4 (K=3),
// every cycle compared against a game-level reference model.
module tb_game_engine_nk;
    logic clk = 1'b0;
    logic rst3, rst4;

    game_engine_nk_if #(.N(3)) if3();
    game_engine_nk_if #(.N(4)) if4();

    game_engine_nk #(.N(3), .K(3)) dut3 (.clk(clk), .reset(rst3), .bus(if3));
    game_engine_nk #(.N(4), .K(3)) dut4 (.clk(clk), .reset(rst4), .bus(if4));

    always #5 clk = ~clk;

    localparam int PH_TURN  = 0;
    localparam int PH_CHECK = 1;
    localparam int PH_DONE  = 2;

    int n_vec = 0;
    int n_err = 0;
    int mn = 3;
    int mk = 3;
    int m_board [36];
    int m_turn, m_phase, m_count, m_winner, m_err, m_mover;
    bit p1s;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Does player p own K in a row anywhere on the model board?
    function automatic bit m_win(input int p);
        int dr [4] = '{0, 1, 1, 1};
        int dc [4] = '{1, 0, 1, -1};
        for (int r = 0; r < mn; r++)
            for (int c = 0; c < mn; c++)
                for (int d = 0; d < 4; d++) begin
                    bit ok = 1'b1;
                    for (int t = 0; t < mk; t++) begin
                        int rr = r + dr[d] * t;
                        int cc = c + dc[d] * t;
                        if (rr < 0 || rr >= mn || cc < 0 || cc >= mn) ok = 1'b0;
                        else if (m_board[rr*mn + cc] != p) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    task automatic model_step(input bit r, input bit ng, input bit p1, input bit wr, input int idx);
        if (r || ng) begin
            foreach (m_board[i]) m_board[i] = 0;
            m_count  = 0;
            m_winner = 0;
            m_err    = 0;
            m_phase  = PH_TURN;
            m_turn   = p1 ? 1 : 2;
        end else begin
            m_err = 0;
            case (m_phase)
                PH_TURN: if (wr) begin
                    if (idx < mn*mn && m_board[idx] == 0) begin
                        m_board[idx] = m_turn;
                        m_count++;
                        m_mover = m_turn;
                        m_phase = PH_CHECK;
                    end else begin
                        m_err = 1;
                    end
                end
                PH_CHECK: begin
                    if (m_win(m_mover)) begin
                        m_phase  = PH_DONE;
                        m_winner = m_mover;
                    end else if (m_count == mn*mn) begin
                        m_phase  = PH_DONE;
                        m_winner = 3;
                    end else begin
                        m_turn  = 3 - m_mover;
                        m_phase = PH_TURN;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare 1 time unit later.
    task automatic step(input bit r, input bit ng, input bit p1, input bit wr,
                        input int idx, input string tag = "cyc");
        logic [71:0] gb, eb;
        logic [2:0]  st;
        logic [1:0]  wn;
        logic [5:0]  mc;
        logic        me;
        logic [3:0]  iv;
        int          es;
        iv = idx[3:0];
        @(negedge clk);
        if (mn == 3) begin
            rst3 = r; if3.newGame = ng; if3.isPlayer1Start = p1;
            if3.playerWrite = wr; if3.playerInput = iv;
        end else begin
            rst4 = r; if4.newGame = ng; if4.isPlayer1Start = p1;
            if4.playerWrite = wr; if4.playerInput = iv;
        end
        @(posedge clk);
        model_step(r, ng, p1, wr, idx);
        #1;
        gb = '0;
        if (mn == 3) begin
            gb[17:0] = if3.gBoard; st = if3.gameState; wn = if3.winner;
            mc = {2'b00, if3.moveCount}; me = if3.moveError;
        end else begin
            gb[31:0] = if4.gBoard; st = if4.gameState; wn = if4.winner;
            mc = {1'b0, if4.moveCount}; me = if4.moveError;
        end
        eb = '0;
        for (int i = 0; i < mn*mn; i++) eb[2*i +: 2] = 2'(m_board[i]);
        case (m_phase)
            PH_TURN:  es = m_turn;
            PH_CHECK: es = 3;
            default:  es = 4;
        endcase
        chk({tag, ".board"},  gb,          eb);
        chk({tag, ".state"},  72'(st),     72'(es));
        chk({tag, ".winner"}, 72'(wn),     72'(m_winner));
        chk({tag, ".count"},  72'(mc),     72'(m_count));
        chk({tag, ".error"},  72'(me),     72'(m_err));
    endtask

    // A move followed by the cycle in which it is judged.
    task automatic mv(input int idx, input string tag);
        step(1'b0, 1'b0, p1s, 1'b1, idx, tag);
        step(1'b0, 1'b0, p1s, 1'b0, 0, tag);
    endtask

    task automatic random_play(input int cycles);
        int  rr, idx;
        bit  r, ng, wr;
        for (int c = 0; c < cycles; c++) begin
            rr  = $urandom_range(0, 199);
            r   = (rr == 0);
            ng  = (rr < 5) || (m_phase == PH_DONE && rr < 60);
            wr  = ($urandom_range(0, 3) != 0);
            idx = $urandom_range(0, 15);
            p1s = $urandom_range(0, 1) != 0;
            step(r, ng, p1s, wr, idx, "rnd");
        end
    endtask

    initial begin
        rst3 = 1'b1; rst4 = 1'b1;
        if3.newGame = 1'b0; if3.isPlayer1Start = 1'b0; if3.playerWrite = 1'b0; if3.playerInput = '0;
        if4.newGame = 1'b0; if4.isPlayer1Start = 1'b0; if4.playerWrite = 1'b0; if4.playerInput = '0;
        foreach (m_board[i]) m_board[i] = 0;
        m_turn = 0; m_phase = PH_TURN; m_count = 0; m_winner = 0; m_err = 0; m_mover = 1;

        // ---------------- N = 3 ----------------
        mn = 3;
        p1s = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, "reset");
        chk("reset_state", 72'(if3.gameState), 72'(3'b010));

        // player 2 takes the anti-diagonal 2-4-6
        mv(4, "ad"); mv(0, "ad"); mv(2, "ad"); mv(1, "ad"); mv(6, "ad");
        chk("ad_board",  72'(if3.gBoard),    72'(18'h02225));
        chk("ad_state",  72'(if3.gameState), 72'(3'b100));
        chk("ad_winner", 72'(if3.winner),    72'(2'b10));
        chk("ad_count",  72'(if3.moveCount), 72'(4'd5));

        // DONE ignores moves; newGame then beats a simultaneous move
        step(1'b0, 1'b0, p1s, 1'b1, 3, "done_wr");
        step(1'b0, 1'b0, p1s, 1'b0, 0, "done_idle");
        p1s = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b1, 4, "ng_wr");
        chk("ng_board", 72'(if3.gBoard),    72'(0));
        chk("ng_state", 72'(if3.gameState), 72'(3'b001));

        // occupied cell, then index past the board
        mv(4, "err");
        step(1'b0, 1'b0, p1s, 1'b1, 4, "err_occ");
        step(1'b0, 1'b0, p1s, 1'b0, 0, "err_occ2");
        step(1'b0, 1'b0, p1s, 1'b1, 9, "err_oob");
        step(1'b0, 1'b0, p1s, 1'b0, 0, "err_oob2");
        chk("err_count", 72'(if3.moveCount), 72'(4'd1));

        // full board, no line
        step(1'b0, 1'b1, 1'b1, 1'b0, 0, "ng2");
        mv(0, "draw"); mv(1, "draw"); mv(2, "draw"); mv(4, "draw"); mv(3, "draw");
        mv(5, "draw"); mv(7, "draw"); mv(6, "draw"); mv(8, "draw");
        chk("draw_winner", 72'(if3.winner),    72'(2'b11));
        chk("draw_count",  72'(if3.moveCount), 72'(4'd9));
        chk("draw_state",  72'(if3.gameState), 72'(3'b100));

        // win on the board-filling move
        step(1'b0, 1'b1, 1'b1, 1'b0, 0, "ng3");
        mv(0, "last"); mv(1, "last"); mv(2, "last"); mv(3, "last"); mv(4, "last");
        mv(5, "last"); mv(7, "last"); mv(6, "last"); mv(8, "last");
        chk("last_winner", 72'(if3.winner), 72'(2'b01));

        // reset in CHECK, and reset over newGame + move
        p1s = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, "ng4");
        step(1'b0, 1'b0, 1'b0, 1'b1, 4, "pre_rst");
        p1s = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, "rst_check");
        chk("rst_check_state", 72'(if3.gameState), 72'(3'b001));
        chk("rst_check_board", 72'(if3.gBoard),    72'(0));
        step(1'b1, 1'b1, 1'b0, 1'b1, 0, "rst_prio");

        random_play(1500);

        // ---------------- N = 4, K = 3 ----------------
        rst3 = 1'b1;
        mn = 4;
        p1s = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, "n4_reset");
        mv(5, "n4"); mv(0, "n4"); mv(10, "n4"); mv(1, "n4"); mv(15, "n4");
        chk("n4_winner", 72'(if4.winner),    72'(2'b01));
        chk("n4_state",  72'(if4.gameState), 72'(3'b100));

        random_play(800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
